// File: rtl/contador_varredura_matriz_pkg.sv
// ----------------------------------------------------------------------------
// matriz_pkg : shared types and default geometry for the LED-matrix scan path
// Revision   : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package matriz_pkg;

  localparam int MATRIZ_NCOL = 5;
  localparam int MATRIZ_NLIN = 7;
  localparam int COORD_W     = 3;

  typedef logic [COORD_W-1:0] coord_t;

endpackage

`default_nettype wire

// File: rtl/contador_varredura_matriz_if.sv
// ----------------------------------------------------------------------------
// contador_varredura_matriz_if : control inputs and scan outputs of the scanner
// Revision                     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface contador_varredura_matriz_if;
  import matriz_pkg::*;

  logic   en;
  logic   restart;
  coord_t mdc;
  coord_t mdl;
  logic   step;
  logic   frame_end;
  logic   blank;

  modport master (
    output en, restart,
    input  mdc, mdl, step, frame_end, blank
  );

  modport slave (
    input  en, restart,
    output mdc, mdl, step, frame_end, blank
  );

endinterface

`default_nettype wire

// File: rtl/contador_varredura_matriz_divisor_tick.sv
// ----------------------------------------------------------------------------
// divisor_tick : free-running modulo-DIV prescaler, tick in the wrap cycle
// Revision     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module divisor_tick #(
  parameter int DIV = 4
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic en,
  input  wire logic clr,
  output logic      tick
);

  localparam int               PRE_W   = $clog2(DIV);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);

  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] pre_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pre_q <= '0;
    else        pre_q <= pre_d;
  end

  // clr suppresses the tick so a restart never produces a step
  always_comb begin
    pre_d = pre_q;
    tick  = 1'b0;
    if (clr) begin
      pre_d = '0;
    end else if (en) begin
      if (pre_q == PRE_MAX) begin
        pre_d = '0;
        tick  = 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/contador_varredura_matriz.sv
// ----------------------------------------------------------------------------
// contador_varredura_matriz : row-major column/line scan generator with
//                             step, frame_end and blank strobes
// Revision                  : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module contador_varredura_matriz
  import matriz_pkg::*;
#(
  parameter int DIV  = 4,
  parameter int NCOL = MATRIZ_NCOL,
  parameter int NLIN = MATRIZ_NLIN
) (
  input  wire logic                   clk,
  input  wire logic                   rst_n,
  contador_varredura_matriz_if.slave  bus
);

  localparam coord_t COL_MAX = coord_t'(NCOL - 1);
  localparam coord_t LIN_MAX = coord_t'(NLIN - 1);

  logic   tick;
  coord_t mdc_q, mdc_d;
  coord_t mdl_q, mdl_d;
  logic   step_q, step_d;
  logic   frame_end_q, frame_end_d;
  logic   blank_q, blank_d;

  divisor_tick #(
    .DIV (DIV)
  ) u_divisor_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bus.en),
    .clr   (bus.restart),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdc_q       <= '0;
      mdl_q       <= '0;
      step_q      <= 1'b0;
      frame_end_q <= 1'b0;
      blank_q     <= 1'b1;
    end else begin
      mdc_q       <= mdc_d;
      mdl_q       <= mdl_d;
      step_q      <= step_d;
      frame_end_q <= frame_end_d;
      blank_q     <= blank_d;
    end
  end

  // Explicit compare-and-wrap keeps coordinates inside NCOL x NLIN
  always_comb begin
    mdc_d       = mdc_q;
    mdl_d       = mdl_q;
    step_d      = 1'b0;
    frame_end_d = 1'b0;
    blank_d     = 1'b1;
    if (bus.restart) begin
      mdc_d = '0;
      mdl_d = '0;
    end else if (bus.en) begin
      step_d  = tick;
      blank_d = tick;
      if (tick) begin
        if (mdc_q != COL_MAX) begin
          mdc_d = mdc_q + 1'b1;
        end else begin
          mdc_d = '0;
          if (mdl_q != LIN_MAX) begin
            mdl_d = mdl_q + 1'b1;
          end else begin
            mdl_d       = '0;
            frame_end_d = 1'b1;
          end
        end
      end
    end
  end

  assign bus.mdc       = mdc_q;
  assign bus.mdl       = mdl_q;
  assign bus.step      = step_q;
  assign bus.frame_end = frame_end_q;
  assign bus.blank     = blank_q;

endmodule

`default_nettype wire

// File: tb/tb_contador_varredura_matriz.sv
// ----------------------------------------------------------------------------
// tb_contador_varredura_matriz : directed bench for the matrix scan generator
// Revision                     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_contador_varredura_matriz;

  typedef struct {
    logic en;
    logic restart;
    int   mdc;
    int   mdl;
    logic step;
    logic fe;
    logic blank;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vecs [32];

  contador_varredura_matriz_if bus ();
  contador_varredura_matriz_if bus2 ();

  contador_varredura_matriz #(
    .DIV  (4),
    .NCOL (5),
    .NLIN (7)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  contador_varredura_matriz #(
    .DIV  (2),
    .NCOL (1),
    .NLIN (1)
  ) u_dut_1x1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) clk_step();
  endtask

  task automatic do_restart();
    bus.restart = 1'b1;
    bus.en      = 1'b1;
    clk_step();
    bus.restart = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int nsteps;
    int nfe;
    int bad_timing;

    // Reset-then-enable sequence, an en=0 pause and a two-cycle restart
    vecs[0]  = '{1, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 0, 0, 0, 0, 0, 0};
    vecs[2]  = '{1, 0, 0, 0, 0, 0, 0};
    vecs[3]  = '{1, 0, 1, 0, 1, 0, 1};
    vecs[4]  = '{1, 0, 1, 0, 0, 0, 0};
    vecs[5]  = '{1, 0, 1, 0, 0, 0, 0};
    vecs[6]  = '{1, 0, 1, 0, 0, 0, 0};
    vecs[7]  = '{1, 0, 2, 0, 1, 0, 1};
    vecs[8]  = '{1, 0, 2, 0, 0, 0, 0};
    vecs[9]  = '{1, 0, 2, 0, 0, 0, 0};
    vecs[10] = '{1, 0, 2, 0, 0, 0, 0};
    vecs[11] = '{1, 0, 3, 0, 1, 0, 1};
    vecs[12] = '{1, 0, 3, 0, 0, 0, 0};
    vecs[13] = '{1, 0, 3, 0, 0, 0, 0};
    vecs[14] = '{1, 0, 3, 0, 0, 0, 0};
    vecs[15] = '{1, 0, 4, 0, 1, 0, 1};
    vecs[16] = '{1, 0, 4, 0, 0, 0, 0};
    vecs[17] = '{1, 0, 4, 0, 0, 0, 0};
    vecs[18] = '{1, 0, 4, 0, 0, 0, 0};
    vecs[19] = '{1, 0, 0, 1, 1, 0, 1};
    vecs[20] = '{1, 0, 0, 1, 0, 0, 0};
    vecs[21] = '{0, 0, 0, 1, 0, 0, 1};
    vecs[22] = '{0, 0, 0, 1, 0, 0, 1};
    vecs[23] = '{1, 0, 0, 1, 0, 0, 0};
    vecs[24] = '{1, 0, 0, 1, 0, 0, 0};
    vecs[25] = '{1, 0, 1, 1, 1, 0, 1};
    vecs[26] = '{1, 1, 0, 0, 0, 0, 1};
    vecs[27] = '{0, 1, 0, 0, 0, 0, 1};
    vecs[28] = '{1, 0, 0, 0, 0, 0, 0};
    vecs[29] = '{1, 0, 0, 0, 0, 0, 0};
    vecs[30] = '{1, 0, 0, 0, 0, 0, 0};
    vecs[31] = '{1, 0, 1, 0, 1, 0, 1};

    bus.en       = 1'b0;
    bus.restart  = 1'b0;
    bus2.en      = 1'b0;
    bus2.restart = 1'b0;
    run(3);

    check("reset_mdc",   int'(bus.mdc), 0);
    check("reset_mdl",   int'(bus.mdl), 0);
    check("reset_step",  int'(bus.step), 0);
    check("reset_fe",    int'(bus.frame_end), 0);
    check("reset_blank", int'(bus.blank), 1);

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 32; i++) begin
      bus.en      = vecs[i].en;
      bus.restart = vecs[i].restart;
      clk_step();
      check($sformatf("vec%0d_mdc", i),   int'(bus.mdc), vecs[i].mdc);
      check($sformatf("vec%0d_mdl", i),   int'(bus.mdl), vecs[i].mdl);
      check($sformatf("vec%0d_step", i),  int'(bus.step), int'(vecs[i].step));
      check($sformatf("vec%0d_fe", i),    int'(bus.frame_end), int'(vecs[i].fe));
      check($sformatf("vec%0d_blank", i), int'(bus.blank), int'(vecs[i].blank));
    end

    // Full frame: 35 steps over 140 cycles, one frame_end on the last
    do_restart();
    nsteps = 0;
    nfe = 0;
    bad_timing = 0;
    for (int c = 1; c <= 140; c++) begin
      clk_step();
      if (bus.step) nsteps++;
      if (bus.frame_end) nfe++;
      if (int'(bus.step) != int'((c % 4) == 0)) bad_timing++;
      if (bus.frame_end && !bus.step) bad_timing++;
    end
    check("frame_mdc",        int'(bus.mdc), 0);
    check("frame_mdl",        int'(bus.mdl), 0);
    check("frame_step",       int'(bus.step), 1);
    check("frame_fe",         int'(bus.frame_end), 1);
    check("frame_nsteps",     nsteps, 35);
    check("frame_nfe",        nfe, 1);
    check("frame_bad_timing", bad_timing, 0);

    // Freeze at (3,2) with prescaler at 2
    do_restart();
    run(54);
    bus.en = 1'b0;
    run(10);
    check("freeze_mdc",   int'(bus.mdc), 3);
    check("freeze_mdl",   int'(bus.mdl), 2);
    check("freeze_blank", int'(bus.blank), 1);
    check("freeze_step",  int'(bus.step), 0);
    bus.en = 1'b1;
    clk_step();
    check("resume1_step", int'(bus.step), 0);
    clk_step();
    check("resume2_step", int'(bus.step), 1);
    check("resume2_mdc",  int'(bus.mdc), 4);
    check("resume2_mdl",  int'(bus.mdl), 2);

    // Restart landing on the tick cycle at (4,6)
    do_restart();
    run(139);
    check("pre_rs_mdc", int'(bus.mdc), 4);
    check("pre_rs_mdl", int'(bus.mdl), 6);
    bus.restart = 1'b1;
    clk_step();
    bus.restart = 1'b0;
    check("rs_mdc",  int'(bus.mdc), 0);
    check("rs_mdl",  int'(bus.mdl), 0);
    check("rs_step", int'(bus.step), 0);
    check("rs_fe",   int'(bus.frame_end), 0);
    for (int c = 1; c <= 3; c++) begin
      clk_step();
      check($sformatf("rs_wait%0d_step", c), int'(bus.step), 0);
    end
    clk_step();
    check("rs_next_step", int'(bus.step), 1);
    check("rs_next_mdc",  int'(bus.mdc), 1);
    check("rs_next_mdl",  int'(bus.mdl), 0);

    // Asynchronous reset mid-step at (2,5)
    do_restart();
    run(110);
    check("arst_pre_mdc", int'(bus.mdc), 2);
    check("arst_pre_mdl", int'(bus.mdl), 5);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_mdc",   int'(bus.mdc), 0);
    check("arst_mdl",   int'(bus.mdl), 0);
    check("arst_step",  int'(bus.step), 0);
    check("arst_fe",    int'(bus.frame_end), 0);
    check("arst_blank", int'(bus.blank), 1);
    @(negedge clk);
    rst_n = 1'b1;
    bus.en = 1'b0;

    // 1x1 matrix with DIV=2
    bus2.en = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      clk_step();
      check($sformatf("m11_c%0d_step", c), int'(bus2.step), int'((c % 2) == 0));
      check($sformatf("m11_c%0d_fe", c),   int'(bus2.frame_end), int'((c % 2) == 0));
      check($sformatf("m11_c%0d_pos", c),  int'({bus2.mdc, bus2.mdl}), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
